// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, drain depth and
// the instruction word that flushed pipeline registers load.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } seq_state_t;

    localparam int DRAIN_CYC_DEF = 3;

    // sll $0,$0,0 -- the canonical MIPS NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Pipeline sequencer: merges load-use stall, branch flush, memory wait and HALT
// drain into per-stage enables/flushes, and keeps cycle/stall counters.
module pipe_ctrl_seq
    import pipe_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_lu,
    input  logic             br_taken,
    input  logic             mem_busy,
    input  logic             halt_d,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DC_W = $clog2(DRAIN_CYC + 1);

    // Enable vector order: {pc, fd, de, em, mw}; flush order: {fd, de, em}
    localparam logic [4:0] EN_ALL    = 5'b11111;
    localparam logic [4:0] EN_BACK   = 5'b00111;
    localparam logic [4:0] EN_NO_PC  = 5'b01111;
    localparam logic [2:0] FL_ALL    = 3'b111;
    localparam logic [2:0] FL_BUBBLE = 3'b010;
    localparam logic [2:0] FL_FD     = 3'b100;

    seq_state_t      state, state_nxt;
    logic [DC_W-1:0] drain_cnt, drain_nxt;
    logic [4:0]      en;
    logic [2:0]      fl;
    logic            stall_inc;
    logic            cycle_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        en        = '0;
        fl        = '0;
        stall_inc = 1'b0;
        case (state)
            // Once memory is ready, MEM_WAIT resolves the cycle exactly as RUN would
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    stall_inc = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (br_taken) begin
                    en        = EN_ALL;
                    fl        = FL_ALL;
                    state_nxt = RUN;
                end else if (stall_lu) begin
                    en        = EN_BACK;
                    fl        = FL_BUBBLE;
                    stall_inc = 1'b1;
                    state_nxt = RUN;
                end else if (halt_d) begin
                    en        = EN_NO_PC;
                    fl        = FL_FD;
                    drain_nxt = DC_W'(DRAIN_CYC);
                    state_nxt = DRAIN;
                end else begin
                    en        = EN_ALL;
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    stall_inc = 1'b1;
                end else if (br_taken) begin
                    // An older taken branch means the HALT was on a wrong path
                    en        = EN_ALL;
                    fl        = FL_ALL;
                    drain_nxt = '0;
                    state_nxt = RUN;
                end else begin
                    en = EN_BACK;
                    fl = FL_BUBBLE;
                    if (drain_cnt <= DC_W'(1)) begin
                        drain_nxt = '0;
                        state_nxt = HALTED;
                    end else begin
                        drain_nxt = drain_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HALTED;
            end
        endcase
        if (!rst_n) begin
            en = '0;
            fl = '0;
        end
    end

    assign cycle_inc = (state != HALTED);
    assign done      = (state == HALTED);

    assign {en_pc, en_fd, en_de, en_em, en_mw} = en;
    assign {flush_fd, flush_de, flush_em}      = fl;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cycle_inc),
        .cnt   (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Bench for pipe_ctrl_seq: directed scenarios then random traffic against a
// cycle-level behavioural model; a 4-bit-counter instance checks saturation.
module tb_pipe_ctrl_seq;

    localparam int DRAIN = 3;

    logic clk, rst_n;
    logic stall_lu, br_taken, mem_busy, halt_d;
    logic en_pc, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, done;
    logic [31:0] cycle_cnt, stall_cnt;
    logic s_en_pc, s_en_fd, s_en_de, s_en_em, s_en_mw, s_flush_fd, s_flush_de, s_flush_em, s_done;
    logic [3:0] s_cycle_cnt, s_stall_cnt;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 = running, 1 = draining, 2 = halted
    int     md, left;
    longint cyc, stl;
    bit     seen_done;

    pipe_ctrl_seq #(.CNT_W(32), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .stall_lu(stall_lu), .br_taken(br_taken),
        .mem_busy(mem_busy), .halt_d(halt_d),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
        .done(done), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl_seq #(.CNT_W(4), .DRAIN_CYC(DRAIN)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall_lu(stall_lu), .br_taken(br_taken),
        .mem_busy(mem_busy), .halt_d(halt_d),
        .en_pc(s_en_pc), .en_fd(s_en_fd), .en_de(s_en_de), .en_em(s_en_em), .en_mw(s_en_mw),
        .flush_fd(s_flush_fd), .flush_de(s_flush_de), .flush_em(s_flush_em),
        .done(s_done), .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    // Called at posedge+1; drives a cycle, checks at negedge, commits model at posedge
    task automatic step(input bit b, input bit br, input bit sl, input bit hd);
        logic [4:0] xe;
        logic [2:0] xf;
        bit sinc;
        int nmd, nleft;
        mem_busy = b; br_taken = br; stall_lu = sl; halt_d = hd;
        #4;
        xe = '0; xf = '0; sinc = 0; nmd = md; nleft = left;
        if (md == 2) begin
            xe = '0;
        end else if (b) begin
            sinc = 1;
        end else if (br) begin
            xe = 5'b11111; xf = 3'b111; nmd = 0; nleft = 0;
        end else if (md == 1) begin
            xe = 5'b00111; xf = 3'b010; nleft = left - 1;
            if (nleft == 0) nmd = 2;
        end else if (sl) begin
            xe = 5'b00111; xf = 3'b010; sinc = 1;
        end else if (hd) begin
            xe = 5'b01111; xf = 3'b100; nmd = 1; nleft = DRAIN;
        end else begin
            xe = 5'b11111;
        end
        check_eq("en", {en_pc, en_fd, en_de, en_em, en_mw}, xe);
        check_eq("flush", {flush_fd, flush_de, flush_em}, xf);
        check_eq("done", done, (md == 2));
        check_eq("cycle_cnt", cycle_cnt, cyc);
        check_eq("stall_cnt", stall_cnt, stl);
        check_eq("s_cycle_cnt", s_cycle_cnt, sat15(cyc));
        check_eq("s_stall_cnt", s_stall_cnt, sat15(stl));
        seen_done = done;
        @(posedge clk);
        if (md != 2) cyc++;
        if (sinc) stl++;
        md = nmd; left = nleft;
        #1;
    endtask

    // Asserted mid-cycle so the asynchronous path is exercised
    task automatic do_reset();
        rst_n = 1'b0;
        mem_busy = 1'b0; br_taken = 1'b1; stall_lu = 1'b1; halt_d = 1'b1;
        #1;
        check_eq("rst_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'b0);
        check_eq("rst_flush", {flush_fd, flush_de, flush_em}, 3'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_cycle", cycle_cnt, 32'd0);
        check_eq("rst_stall", stall_cnt, 32'd0);
        md = 0; left = 0; cyc = 0; stl = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_busy = 1'b0; br_taken = 1'b0; stall_lu = 1'b0; halt_d = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        mem_busy = 1'b0; br_taken = 1'b0; stall_lu = 1'b0; halt_d = 1'b0;
        md = 0; left = 0; cyc = 0; stl = 0; seen_done = 0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check_eq("t1_cycle10", cycle_cnt, 32'd10);
        check_eq("t1_stall0", stall_cnt, 32'd0);

        step(0, 0, 1, 0);
        check_eq("t2_stall1", stall_cnt, 32'd1);
        step(0, 0, 0, 0);

        step(0, 1, 1, 1);
        step(0, 0, 0, 0);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        check_eq("t4_stall5", stall_cnt, 32'd5);
        step(0, 0, 0, 0);

        step(0, 0, 0, 1);
        n = 0;
        do begin step(0, 0, 0, 0); n++; end while (!seen_done && n < 20);
        check_eq("t5_halt_lat", n, 4);
        n = int'(cycle_cnt);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        check_eq("t5_cyc_frozen", cycle_cnt, n);

        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n = 3;
        do begin step(0, 0, 0, 0); n++; end while (!seen_done && n < 20);
        check_eq("t5_busy_lat", n, 6);

        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check_eq("t6_br_cancel_done", done, 1'b0);

        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check_eq("t6_sat15", s_cycle_cnt, 4'hF);
        check_eq("t6_full_cyc", cycle_cnt, 32'd20);

        for (int i = 0; i < 600; i++) begin
            if ((md == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 6);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
